lsb_mem_ctrl: RTL

- Responder side of the LSB-to-memory request/response handshake.
- Accepts one load or store request at a time from the LSB: call_valid, call_is_store, call_addr, call_len, call_data.
- Executes the request as 1/2/4 byte-wide accesses on the single-port synchronous RAM/IO bus.
- Returns a single-cycle respond_valid pulse with little-endian assembled load data.
- Sits between the LSB and the top-level memory bus pins.

---
 rtl/lsb_mem_ctrl_pkg.sv | 19 +
 rtl/lsb_mem_ctrl_if.sv | 31 +++
 rtl/lsb_mem_ctrl.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/lsb_mem_ctrl_pkg.sv
// rtl/lsb_mem_ctrl_pkg.sv - shared widths, IO space tag and FSM states for lsb_mem_ctrl
// Contents: ADDR_WID, DATA_WID, ST_LEN_WID, IO_ADDR_HI, state_t
package lsb_mem_ctrl_pkg;

    localparam int ADDR_WID   = 32;
    localparam int DATA_WID   = 32;
    localparam int ST_LEN_WID = 3;

    // Value of address bits [17:16] that selects the IO (UART) space.
    localparam logic [1:0] IO_ADDR_HI = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/lsb_mem_ctrl_if.sv
// rtl/lsb_mem_ctrl_if.sv - LSB request/response handshake between LSB and memory controller
// Signals: call_valid, call_is_store, call_addr, call_len, call_data (LSB -> ctrl)
//          respond_valid, respond_data (ctrl -> LSB)
// Modports: master = LSB side, slave = memory controller side
interface lsb_mem_ctrl_if
    import lsb_mem_ctrl_pkg::*;
#(
    parameter int ADDR_W = ADDR_WID,
    parameter int DATA_W = DATA_WID,
    parameter int LEN_W  = ST_LEN_WID
) ();

    logic              call_valid;
    logic              call_is_store;
    logic [ADDR_W-1:0] call_addr;
    logic [LEN_W-1:0]  call_len;
    logic [DATA_W-1:0] call_data;
    logic              respond_valid;
    logic [DATA_W-1:0] respond_data;

    modport master (
        output call_valid, call_is_store, call_addr, call_len, call_data,
        input  respond_valid, respond_data
    );

    modport slave (
        input  call_valid, call_is_store, call_addr, call_len, call_data,
        output respond_valid, respond_data
    );

endinterface

// File: rtl/lsb_mem_ctrl.sv
// rtl/lsb_mem_ctrl.sv - LSB-side memory responder: byte-serial load/store on the RAM/IO bus
// Ports: clk, rst (sync, active high), rdy (global enable), rollback (ROB flush)
//        lsb (lsb_mem_ctrl_if.slave): request in, one-cycle response out
//        mem_a, mem_dout, mem_wr (registered RAM bus outputs), mem_din (RAM read byte)
//        io_buffer_full (UART buffer full, used only with LSB_MEM_CTRL_IO_STALL_EN)
// Option: LSB_MEM_CTRL_IO_STALL_EN holds IO-space store bytes while io_buffer_full is high
module lsb_mem_ctrl
    import lsb_mem_ctrl_pkg::*;
#(
    parameter int ADDR_W = ADDR_WID,
    parameter int DATA_W = DATA_WID,
    parameter int LEN_W  = ST_LEN_WID
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              rollback,
    lsb_mem_ctrl_if.slave     lsb,
    output logic [ADDR_W-1:0] mem_a,
    output logic [7:0]        mem_dout,
    output logic              mem_wr,
    input  logic [7:0]        mem_din,
    input  logic              io_buffer_full
);

    state_t            state, state_next;
    logic [ADDR_W-1:0] addr_q, addr_next;
    logic [ADDR_W-1:0] mem_a_q, mem_a_next;
    logic [LEN_W-1:0]  len_q, len_next;
    logic [LEN_W-1:0]  issue_cnt, issue_next;
    logic [LEN_W-1:0]  recv_cnt, recv_next;
    logic [DATA_W-1:0] data_q, data_next;
    logic [DATA_W-1:0] asm_q, asm_next;
    logic [DATA_W-1:0] rdata_q, rdata_next;
    logic [7:0]        dout_q, dout_next;
    logic              wr_q, wr_next;
    logic              rv_q, rv_next;
    // Read data lags the issued address by two edges; primed marks that the
    // first byte is on mem_din from the next READ edge onwards.
    logic              primed_q, primed_next;
    logic              accept_stall;
    logic              write_stall;

`ifdef LSB_MEM_CTRL_IO_STALL_EN
    assign accept_stall = (lsb.call_addr[17:16] == IO_ADDR_HI) && io_buffer_full;
    assign write_stall  = (addr_q[17:16] == IO_ADDR_HI) && io_buffer_full;
`else
    logic unused_io_buffer_full;
    assign unused_io_buffer_full = io_buffer_full;
    assign accept_stall = 1'b0;
    assign write_stall  = 1'b0;
`endif

    always_comb begin
        state_next  = state;
        addr_next   = addr_q;
        mem_a_next  = mem_a_q;
        len_next    = len_q;
        issue_next  = issue_cnt;
        recv_next   = recv_cnt;
        data_next   = data_q;
        asm_next    = asm_q;
        rdata_next  = rdata_q;
        dout_next   = dout_q;
        wr_next     = wr_q;
        rv_next     = 1'b0;
        primed_next = primed_q;

        case (state)
            ST_IDLE: begin
                if (lsb.call_valid && !rollback) begin
                    addr_next  = lsb.call_addr;
                    len_next   = (lsb.call_len == '0) ? LEN_W'(1) : lsb.call_len;
                    data_next  = lsb.call_data;
                    mem_a_next = lsb.call_addr;
                    if (lsb.call_is_store) begin
                        state_next = ST_WRITE;
                        if (accept_stall) begin
                            issue_next = '0;
                            wr_next    = 1'b0;
                        end else begin
                            issue_next = LEN_W'(1);
                            dout_next  = lsb.call_data[7:0];
                            wr_next    = 1'b1;
                        end
                    end else begin
                        state_next  = ST_READ;
                        issue_next  = LEN_W'(1);
                        wr_next     = 1'b0;
                        recv_next   = '0;
                        asm_next    = '0;
                        primed_next = 1'b0;
                    end
                end
            end

            ST_WRITE: begin
                // Stores are committed, so rollback never cuts them short.
                if (issue_cnt == len_q) begin
                    wr_next    = 1'b0;
                    rv_next    = 1'b1;
                    state_next = ST_DONE;
                end else if (write_stall) begin
                    wr_next = 1'b0;
                end else begin
                    mem_a_next = addr_q + ADDR_W'(issue_cnt);
                    dout_next  = data_q[{issue_cnt[1:0], 3'b000} +: 8];
                    wr_next    = 1'b1;
                    issue_next = issue_cnt + LEN_W'(1);
                end
            end

            ST_READ: begin
                if (rollback) begin
                    state_next = ST_IDLE;
                end else begin
                    if (issue_cnt < len_q) begin
                        mem_a_next = addr_q + ADDR_W'(issue_cnt);
                        issue_next = issue_cnt + LEN_W'(1);
                    end
                    if (primed_q) begin
                        asm_next[{recv_cnt[1:0], 3'b000} +: 8] = mem_din;
                        if (recv_cnt == len_q - LEN_W'(1)) begin
                            rdata_next = asm_next;
                            rv_next    = 1'b1;
                            state_next = ST_DONE;
                        end else begin
                            recv_next = recv_cnt + LEN_W'(1);
                        end
                    end
                    primed_next = 1'b1;
                end
            end

            ST_DONE: begin
                // The LSB still holds call_valid in the respond cycle; ignore it here.
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            addr_q    <= '0;
            mem_a_q   <= '0;
            len_q     <= '0;
            issue_cnt <= '0;
            recv_cnt  <= '0;
            data_q    <= '0;
            asm_q     <= '0;
            rdata_q   <= '0;
            dout_q    <= '0;
            wr_q      <= 1'b0;
            rv_q      <= 1'b0;
            primed_q  <= 1'b0;
        end else if (rdy || (rollback && state == ST_READ)) begin
            state     <= state_next;
            addr_q    <= addr_next;
            mem_a_q   <= mem_a_next;
            len_q     <= len_next;
            issue_cnt <= issue_next;
            recv_cnt  <= recv_next;
            data_q    <= data_next;
            asm_q     <= asm_next;
            rdata_q   <= rdata_next;
            dout_q    <= dout_next;
            wr_q      <= wr_next;
            rv_q      <= rv_next;
            primed_q  <= primed_next;
        end
    end

    assign mem_a             = mem_a_q;
    assign mem_dout          = dout_q;
    assign mem_wr            = wr_q & rdy;
    assign lsb.respond_valid = rv_q;
    assign lsb.respond_data  = rdata_q;

endmodule
